zkbdmus_fifo: RTL

// Next-generation keyboard/mouse/joystick data hub between slavespi and zports.

---
 rtl/zkbdmus_fifo_if.sv | 47 ++++
 rtl/zkbdmus_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/zkbdmus_fifo_if.sv
// zkbdmus_fifo_if
// Bus bundle between the SPI-side/Z80-side host logic and the keyboard/mouse
// hub. The host (master) drives strobes, data and the Z80 address high byte;
// the hub (slave) returns the matrix read, mouse/joystick bytes and the
// scan-code FIFO head and status.
//   kbd_in/kbd_stb                      key matrix load
//   mus_in/mus_xstb/mus_ystb/mus_btnstb mouse updates (shared data byte)
//   kj_stb                              joystick byte load (uses mus_in)
//   key_in/key_stb/key_rd/ovf_clr       scan-code FIFO push/pop/flag clear
//   zah                                 Z80 address high byte
//   kbd_data/mus_data/kj_data           port read data
//   key_data/key_empty/key_ovf          FIFO head and status
interface zkbdmus_fifo_if #(
  parameter int KBD_ROWS = 8,
  parameter int KBD_COLS = 5
);
  logic [KBD_ROWS*KBD_COLS-1:0] kbd_in;
  logic                         kbd_stb;
  logic [7:0]                   mus_in;
  logic                         mus_xstb;
  logic                         mus_ystb;
  logic                         mus_btnstb;
  logic                         kj_stb;
  logic [7:0]                   key_in;
  logic                         key_stb;
  logic                         key_rd;
  logic                         ovf_clr;
  logic [7:0]                   zah;
  logic [KBD_COLS-1:0]          kbd_data;
  logic [7:0]                   mus_data;
  logic [7:0]                   kj_data;
  logic [7:0]                   key_data;
  logic                         key_empty;
  logic                         key_ovf;

  modport master (
    output kbd_in, kbd_stb, mus_in, mus_xstb, mus_ystb, mus_btnstb, kj_stb,
           key_in, key_stb, key_rd, ovf_clr, zah,
    input  kbd_data, mus_data, kj_data, key_data, key_empty, key_ovf
  );

  modport slave (
    input  kbd_in, kbd_stb, mus_in, mus_xstb, mus_ystb, mus_btnstb, kj_stb,
           key_in, key_stb, key_rd, ovf_clr, zah,
    output kbd_data, mus_data, kj_data, key_data, key_empty, key_ovf
  );
endinterface

// File: rtl/zkbdmus_fifo.sv
// zkbdmus_fifo
// Keyboard/mouse/joystick data hub. Latches the key matrix, Kempston mouse
// and joystick bytes from SPI-side strobes, answers the ZX matrix read and
// the mouse port reads, and keeps a small circular FIFO of scan codes.
// Ports:
//   fclk   system clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    zkbdmus_fifo_if.slave, see the interface file for the signal list
module zkbdmus_fifo #(
  parameter int KBD_ROWS  = 8,
  parameter int KBD_COLS  = 5,
  parameter int MUS_DELTA = 1,
  parameter int FIFO_LOG2 = 3
) (
  input  logic                 fclk,
  input  logic                 rst_n,
  zkbdmus_fifo_if.slave        bus
);

  localparam int                 DEPTH    = 1 << FIFO_LOG2;
  localparam int                 KBD_BITS = KBD_ROWS * KBD_COLS;
  localparam logic [FIFO_LOG2:0]   FULL_CNT = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2:0]   CNT_ONE  = (FIFO_LOG2+1)'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);

  // ---------------------------------------------------------------------------
  // Key matrix, mouse and joystick registers
  // ---------------------------------------------------------------------------
  logic [KBD_BITS-1:0] kbd_q, kbd_d;
  logic [7:0]          musx_q, musx_d;
  logic [7:0]          musy_q, musy_d;
  logic [7:0]          musbtn_q, musbtn_d;
  logic [7:0]          kj_q, kj_d;

  always_comb begin
    kbd_d    = kbd_q;
    musx_d   = musx_q;
    musy_d   = musy_q;
    musbtn_d = musbtn_q;
    kj_d     = kj_q;

    if (bus.kbd_stb) kbd_d = bus.kbd_in;

    // x and y strobes are independent; both may fire with the same byte
    if (bus.mus_xstb) begin
      if (MUS_DELTA != 0) musx_d = musx_q + bus.mus_in;
      else                musx_d = bus.mus_in;
    end
    if (bus.mus_ystb) begin
      if (MUS_DELTA != 0) musy_d = musy_q + bus.mus_in;
      else                musy_d = bus.mus_in;
    end

    if (bus.mus_btnstb) musbtn_d = bus.mus_in;
    if (bus.kj_stb)     kj_d     = bus.mus_in;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_q    <= '0;
      musx_q   <= 8'h00;
      musy_q   <= 8'h00;
      musbtn_q <= 8'hFF;
      kj_q     <= 8'h00;
    end else begin
      kbd_q    <= kbd_d;
      musx_q   <= musx_d;
      musy_q   <= musy_d;
      musbtn_q <= musbtn_d;
      kj_q     <= kj_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Port reads
  // ---------------------------------------------------------------------------
  // Matrix bit r+KBD_ROWS*c is row r column c; every selected row (zah[r]=0)
  // pulls its pressed columns low. zah bits above KBD_ROWS-1 never select.
  logic [KBD_COLS-1:0] kbd_rd_c;

  always_comb begin
    kbd_rd_c = '1;
    for (int r = 0; r < KBD_ROWS; r++) begin
      if (!bus.zah[r]) begin
        for (int c = 0; c < KBD_COLS; c++) begin
          if (kbd_q[r + KBD_ROWS*c]) kbd_rd_c[c] = 1'b0;
        end
      end
    end
  end

  logic [7:0] mus_rd_c;

  always_comb begin
    mus_rd_c = musy_q;
    if (!bus.zah[0])      mus_rd_c = musbtn_q;
    else if (!bus.zah[2]) mus_rd_c = musx_q;
  end

  assign bus.kbd_data = kbd_rd_c;
  assign bus.mus_data = mus_rd_c;
  assign bus.kj_data  = kj_q;

  // ---------------------------------------------------------------------------
  // Scan-code FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]           mem_q [DEPTH];
  logic [7:0]           mem_d [DEPTH];
  logic [FIFO_LOG2-1:0] wr_q, wr_d;
  logic [FIFO_LOG2-1:0] rd_q, rd_d;
  logic [FIFO_LOG2:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 do_push;
  logic                 do_pop;

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);

  // A full FIFO still accepts a push when a pop frees the head in the same
  // cycle; a pop on an empty FIFO is simply ignored.
  assign do_push = bus.key_stb && (!fifo_full || bus.key_rd);
  assign do_pop  = bus.key_rd && !fifo_empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;

    if (do_push) begin
      mem_d[wr_q] = bus.key_in;
      wr_d        = wr_q + PTR_ONE;
    end
    if (do_pop) rd_d = rd_q + PTR_ONE;

    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_ONE;
    else if (do_pop && !do_push) cnt_d = cnt_q - CNT_ONE;

    // set wins over clear when both happen together
    if (bus.ovf_clr) ovf_d = 1'b0;
    if (bus.key_stb && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.key_data  = fifo_empty ? 8'h00 : mem_q[rd_q];
  assign bus.key_empty = fifo_empty;
  assign bus.key_ovf   = ovf_q;

endmodule
